// File: rtl/alu_result_stage_if.sv
// Bus between the ALU, the result stage and the register-file writeback port.
// The master drives ALU results and the downstream ready; the slave is the stage.
interface alu_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_c;
  logic        alu_z;
  logic [1:0]  cz_mod;
  logic [1:0]  cond;
  logic [2:0]  rd;
  logic        wr_req;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_en;
  logic        c_flag;
  logic        z_flag;

  modport master (
    output in_valid, alu_out, alu_c, alu_z, cz_mod, cond, rd, wr_req, flush, out_ready,
    input  in_ready, out_valid, wb_data, wb_rd, wb_en, c_flag, z_flag
  );

  modport slave (
    input  in_valid, alu_out, alu_c, alu_z, cz_mod, cond, rd, wr_req, flush, out_ready,
    output in_ready, out_valid, wb_data, wb_rd, wb_en, c_flag, z_flag
  );
endinterface

// File: rtl/alu_result_stage.sv
// One-entry result register between the ALU and writeback; owns the C/Z flags
// and squashes conditional instructions whose condition fails.
//
// state | meaning
// EMPTY | no writeback beat held, out_valid = 0
// FULL  | beat held on wb_*, out_valid = 1, waits for out_ready
module alu_result_stage (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_stage_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_en;
  logic        c_flag;
  logic        z_flag;

  logic        in_ready;
  logic        accept;
  logic        cond_ok;

  assign in_ready = (state == EMPTY) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Condition is judged against the flags as they stand before this instruction
  always_comb begin
    cond_ok = 1'b1;
    case (bus.cond)
      2'b10:   cond_ok = c_flag;
      2'b01:   cond_ok = z_flag;
      default: cond_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      wb_data <= 16'h0000;
      wb_rd   <= 3'b000;
      wb_en   <= 1'b0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
    end else if (bus.flush) begin
      state <= EMPTY;
      wb_en <= 1'b0;
    end else if (accept) begin
      state   <= FULL;
      wb_data <= bus.alu_out;
      wb_rd   <= bus.rd;
      wb_en   <= cond_ok && bus.wr_req;
      if (cond_ok && bus.cz_mod[1]) c_flag <= bus.alu_c;
      if (cond_ok && bus.cz_mod[0]) z_flag <= bus.alu_z;
    end else if ((state == FULL) && bus.out_ready) begin
      // Drained beat: keep data for visibility but never leave a write enable behind
      state <= EMPTY;
      wb_en <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.wb_data   = wb_data;
  assign bus.wb_rd     = wb_rd;
  assign bus.wb_en     = wb_en;
  assign bus.c_flag    = c_flag;
  assign bus.z_flag    = z_flag;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic c, input logic z,
                       input logic [1:0] mod, input logic [1:0] cnd, input logic [2:0] r,
                       input logic wr);
    bus.in_valid = v;
    bus.alu_out  = d;
    bus.alu_c    = c;
    bus.alu_z    = z;
    bus.cz_mod   = mod;
    bus.cond     = cnd;
    bus.rd       = r;
    bus.wr_req   = wr;
  endtask

  task automatic chk_beat(input string tag, input logic ov, input logic [15:0] d,
                          input logic [2:0] r, input logic en, input logic c, input logic z);
    chk({tag, ".out_valid"}, bus.out_valid, ov);
    chk({tag, ".wb_data"},   bus.wb_data,   d);
    chk({tag, ".wb_rd"},     bus.wb_rd,     r);
    chk({tag, ".wb_en"},     bus.wb_en,     en);
    chk({tag, ".c_flag"},    bus.c_flag,    c);
    chk({tag, ".z_flag"},    bus.z_flag,    z);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    #12;
    chk_beat("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    // First accept on first edge after release
    drive(1'b1, 16'h1234, 1'b1, 1'b0, 2'b11, 2'b00, 3'd3, 1'b1);
    tick();
    chk_beat("first", 1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b0);

    drive(1'b1, 16'h5555, 1'b0, 1'b0, 2'b11, 2'b00, 3'd1, 1'b1);
    tick();
    chk_beat("clr_c", 1'b1, 16'h5555, 3'd1, 1'b1, 1'b0, 1'b0);

    // cond=10 with C=0: squashed, flags hold
    drive(1'b1, 16'h0000, 1'b1, 1'b1, 2'b11, 2'b10, 3'd2, 1'b1);
    tick();
    chk_beat("squash_c", 1'b1, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b0);

    // C set at edge N is seen by the cond=10 instruction at edge N+1
    drive(1'b1, 16'h00AA, 1'b1, 1'b0, 2'b11, 2'b00, 3'd4, 1'b1);
    tick();
    chk_beat("set_c", 1'b1, 16'h00AA, 3'd4, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 16'h00BB, 1'b0, 1'b0, 2'b00, 2'b10, 3'd5, 1'b1);
    tick();
    chk_beat("fwd_c", 1'b1, 16'h00BB, 3'd5, 1'b1, 1'b1, 1'b0);

    drive(1'b1, 16'h00CC, 1'b0, 1'b1, 2'b11, 2'b01, 3'd6, 1'b1);
    tick();
    chk_beat("squash_z", 1'b1, 16'h00CC, 3'd6, 1'b0, 1'b1, 1'b0);

    // Stall three cycles with a new result waiting
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hDDDD, 1'b0, 1'b1, 2'b11, 2'b00, 3'd7, 1'b1);
    #1;
    chk("stall.in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat("stall", 1'b1, 16'h00CC, 3'd6, 1'b0, 1'b1, 1'b0);
      chk("stall.in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", bus.in_ready, 1'b1);
    tick();
    chk_beat("release", 1'b1, 16'hDDDD, 3'd7, 1'b1, 1'b0, 1'b1);

    // Only C updated, Z holds; wr_req=0 gives wb_en=0
    drive(1'b1, 16'h0101, 1'b1, 1'b0, 2'b10, 2'b11, 3'd2, 1'b0);
    tick();
    chk_beat("c_only", 1'b1, 16'h0101, 3'd2, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 16'h0102, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 1'b1);
    tick();
    chk_beat("no_mod", 1'b1, 16'h0102, 3'd1, 1'b1, 1'b1, 1'b1);

    // Flush beats a valid incoming result and a held beat
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    drive(1'b1, 16'hF00F, 1'b0, 1'b0, 2'b11, 2'b00, 3'd5, 1'b1);
    tick();
    chk_beat("flush", 1'b0, 16'h0102, 3'd1, 1'b0, 1'b1, 1'b1);
    bus.flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 1'b1);
    #1;
    chk("empty.in_ready", bus.in_ready, 1'b1);
    tick();
    chk("idle.out_valid", bus.out_valid, 1'b0);

    // Accept then drain
    drive(1'b1, 16'h0202, 1'b0, 1'b0, 2'b00, 2'b00, 3'd7, 1'b1);
    tick();
    chk_beat("pre_drain", 1'b1, 16'h0202, 3'd7, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b11, 2'b00, 3'd0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    chk_beat("drain", 1'b0, 16'h0202, 3'd7, 1'b0, 1'b1, 1'b1);

    // Async reset mid-beat while stalled
    drive(1'b1, 16'h0303, 1'b1, 1'b1, 2'b11, 2'b00, 3'd3, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    #2;
    chk("pre_rst.c_flag", bus.c_flag, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_beat("async_rst", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    // After reset C=0 again, so a cond=10 instruction is squashed
    drive(1'b1, 16'h4444, 1'b1, 1'b1, 2'b11, 2'b10, 3'd4, 1'b1);
    tick();
    chk_beat("post_rst", 1'b1, 16'h4444, 3'd4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: in_valid  input  1  upstream ALU result present this cycle.
REQ-004: in_ready  output  1  stage can accept the result this cycle.
REQ-005: alu_out  input  16  ALU result word.
REQ-006: alu_c / alu_z  input  1 each  ALU carry and zero outputs for this result.
REQ-007: cz_mod  input  2  bit1 = instruction may update C, bit0 = instruction may update Z.
REQ-008: cond  input  2  00 always, 10 execute only if C flag = 1, 01 execute only if Z flag = 1, 11 always.
REQ-009: rd  input  3  destination register index.
REQ-010: wr_req  input  1  instruction writes a register.
REQ-011: flush  input  1  discard held and incoming results.
REQ-012: out_valid  output  1  writeback beat present.
REQ-013: out_ready  input  1  downstream writeback port accepts the beat.
REQ-014: wb_data  output  16  registered result word.
REQ-015: wb_rd  output  3  registered destination index.
REQ-016: wb_en  output  1  register write enable for the held beat; 0 for squashed beats.
REQ-017: c_flag / z_flag  output  1 each  architectural carry and zero flags.

Function
REQ-018: Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-019: in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready && !flush.
REQ-020: EMPTY -> FULL on accept; FULL -> EMPTY on out_ready && !accept; FULL -> FULL on accept with out_ready (back-to-back, one beat per cycle); FULL holds all outputs stable while out_ready = 0.
REQ-021: Latency: a result accepted at edge N appears on wb_* with out_valid = 1 after edge N, i.e. one cycle.
REQ-022: Condition met (cond_ok) evaluated at accept time against the current c_flag/z_flag, before this instruction's own update.
REQ-023: On accept with cond_ok: wb_data <= alu_out, wb_rd <= rd, wb_en <= wr_req; c_flag <= alu_c if cz_mod[1]; z_flag <= alu_z if cz_mod[0]; flags without the mod bit hold.
REQ-024: On accept without cond_ok: beat still issued (out_valid = 1), wb_data <= alu_out, wb_rd <= rd, wb_en <= 0; both flags hold.
REQ-025: Flags change only on accept; never on stall, drain, or flush.
REQ-026: Flush has priority over everything: on a flush cycle the next state is EMPTY, the incoming result is not accepted, flags hold, wb_data/wb_rd hold their values, wb_en <= 0.
REQ-027: in_valid while in_ready = 0: no state change; upstream holds its inputs (not this block's duty to check).
REQ-028: Back-to-back flag dependency: instruction accepted at edge N+1 sees flags written at edge N.
REQ-029: wb_en is never 1 while out_valid = 0.

Reset
REQ-030: On rst_n = 0, immediately and independent of clk: state EMPTY, out_valid = 0, wb_data = 16'h0000, wb_rd = 3'b000, wb_en = 0, c_flag = 0, z_flag = 0.
REQ-031: Reset asserted mid-beat (FULL, out_ready = 0) drops the beat; first accept after release behaves as from power-up.
REQ-032: First accept possible at the first rising edge with rst_n = 1.

Verification
REQ-033: After reset, in_valid = 1, alu_out = 16'h1234, alu_c = 1, alu_z = 0, cz_mod = 11, cond = 00, rd = 3, wr_req = 1, out_ready = 1 -> next cycle out_valid = 1, wb_data = 16'h1234, wb_rd = 3, wb_en = 1, c_flag = 1, z_flag = 0.
REQ-034: With c_flag = 0, accept cond = 10, alu_out = 16'h0000, alu_z = 1, cz_mod = 11, wr_req = 1 -> out_valid = 1, wb_en = 0, c_flag = 0, z_flag = 0 (unchanged).
REQ-035: FULL with out_ready = 0 for 3 cycles, in_valid = 1 throughout -> in_ready = 0, wb_* and flags stable for 3 cycles; on out_ready = 1, new beat loads next edge with no gap.
REQ-036: Accept cz_mod = 11 setting c = 1 at edge N, then cond = 10 instruction at edge N+1 -> second beat wb_en = 1 (flag forwarded by register).
REQ-037: flush = 1 with out_valid = 1 and in_valid = 1, alu_c = 1, cz_mod = 11 -> next cycle out_valid = 0, wb_en = 0, flags unchanged, in_valid beat lost.
REQ-038: rst_n pulled low between clock edges while FULL with c_flag = 1 -> out_valid, c_flag, z_flag go 0 without a clock edge.
